// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the data-RAM arbiter: cycle types, arbiter
// states and the request bundle routed from a master to the slave.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
  } wb_req_t;

  localparam wb_req_t WB_REQ_IDLE = '{adr: '0, dat: '0, sel: '0, we: 1'b0,
                                      cyc: 1'b0, stb: 1'b0, cti: CTI_CLASSIC};

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts strobed cycles without ack and pulses err for one
// cycle when the count reaches TIMEOUT-1; ack in that cycle suppresses err.
module wb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en,
  input  logic stb,
  input  logic ack,
  output logic err
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd;

  assign err = en & stb & ~ack & (wd == WD_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          wd <= '0;
    else if (!en || !stb || ack || err)   wd <= '0;
    else                                  wd <= wd + 8'd1;
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two-master / one-slave Wishbone arbiter for the shared data RAM. Grant is
// held for a whole cyc assertion; the datapath mux is purely combinational.
module wb_ram_arbiter
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter bit PRIO_M0 = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [2:0]  m0_cti_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [2:0]  m1_cti_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [2:0]  s_cti_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  arb_state_e state;
  logic       lg;
  wb_req_t    m0_req, m1_req, cur;
  logic       gnt0, gnt1, wd_err;

  assign m0_req = '{adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i, we: m0_we_i,
                    cyc: m0_cyc_i, stb: m0_stb_i, cti: m0_cti_i};
  assign m1_req = '{adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i, we: m1_we_i,
                    cyc: m1_cyc_i, stb: m1_stb_i, cti: m1_cti_i};

  assign gnt0 = (state == ARB_GNT0);
  assign gnt1 = (state == ARB_GNT1);

  always_comb begin
    cur = WB_REQ_IDLE;
    if (gnt0)      cur = m0_req;
    else if (gnt1) cur = m1_req;
  end

  // Only cycles still owned by the master count toward the timeout.
  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en     (cur.cyc),
    .stb    (cur.stb),
    .ack    (s_ack_i),
    .err    (wd_err)
  );

  assign s_adr_o = cur.adr;
  assign s_dat_o = cur.dat;
  assign s_sel_o = cur.sel;
  assign s_we_o  = cur.we;
  assign s_cyc_o = cur.cyc;
  assign s_stb_o = cur.stb & ~wd_err;
  assign s_cti_o = cur.cti;

  assign m0_ack_o = gnt0 & s_ack_i;
  assign m1_ack_o = gnt1 & s_ack_i;
  assign m0_err_o = gnt0 & wd_err;
  assign m1_err_o = gnt1 & wd_err;
  assign m0_dat_o = gnt0 ? s_dat_i : '0;
  assign m1_dat_o = gnt1 ? s_dat_i : '0;

  // lg remembers the last owner; on a tie the other master wins. Every release
  // passes through IDLE so the slave's registered ack drains before handover.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ARB_IDLE;
      lg    <= 1'b1;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || PRIO_M0 || lg)) begin
            state <= ARB_GNT0;
            lg    <= 1'b0;
          end else if (m1_cyc_i) begin
            state <= ARB_GNT1;
            lg    <= 1'b1;
          end
        end
        ARB_GNT0: if (!m0_cyc_i) state <= ARB_IDLE;
        ARB_GNT1: if (!m1_cyc_i) state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter: table of per-cycle vectors plus
// hand-written sequences for write/read, priority, burst, watchdog and reset.
module tb_wb_ram_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] m0_dat_i, m0_adr_i, m1_dat_i, m1_adr_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
  logic [2:0]  m0_cti_i, m1_cti_i;

  logic [31:0] m0_dat_o, m1_dat_o, s_dat_o, s_adr_o, s_dat_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [2:0]  s_cti_o;

  logic [31:0] p_m0_dat_o, p_m1_dat_o, p_s_dat_o, p_s_adr_o;
  logic        p_m0_ack_o, p_m0_err_o, p_m1_ack_o, p_m1_err_o;
  logic [3:0]  p_s_sel_o;
  logic        p_s_we_o, p_s_cyc_o, p_s_stb_o;
  logic [2:0]  p_s_cti_o;

  // slave stimulus: either table-driven or a 1-cycle-ack RAM model
  logic        model_en, tb_ack, ack_q;
  logic [31:0] tb_dat;
  logic [31:0] mem [16];

  assign s_ack_i = model_en ? ack_q : tb_ack;
  assign s_dat_i = model_en ? (ack_q ? mem[s_adr_o[5:2]] : 32'h0) : tb_dat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_q <= 1'b0;
    else begin
      ack_q <= s_cyc_o & s_stb_o & ~ack_q;
      if (s_cyc_o & s_stb_o & s_we_o & ~ack_q) mem[s_adr_o[5:2]] <= s_dat_o;
    end
  end

  wb_ram_arbiter #(.TIMEOUT(16), .PRIO_M0(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_dat_i(m0_dat_i), .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_dat_i(m1_dat_i), .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  wb_ram_arbiter #(.TIMEOUT(16), .PRIO_M0(1'b1)) dut_p (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_dat_i(m0_dat_i), .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i),
    .m0_dat_o(p_m0_dat_o), .m0_ack_o(p_m0_ack_o), .m0_err_o(p_m0_err_o),
    .m1_dat_i(m1_dat_i), .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i),
    .m1_dat_o(p_m1_dat_o), .m1_ack_o(p_m1_ack_o), .m1_err_o(p_m1_err_o),
    .s_dat_o(p_s_dat_o), .s_adr_o(p_s_adr_o), .s_sel_o(p_s_sel_o), .s_we_o(p_s_we_o),
    .s_cyc_o(p_s_cyc_o), .s_stb_o(p_s_stb_o), .s_cti_o(p_s_cti_o),
    .s_dat_i(tb_dat), .s_ack_i(tb_ack)
  );

  int total = 0, bad = 0;
  int a0 = 0, a1 = 0;

  always @(negedge clk) begin
    if (m0_ack_o) a0++;
    if (m1_ack_o) a1++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // waits at negedges for the master's ack; returns read data seen with it
  task automatic wait_ack(input int m, output bit got, output logic [31:0] d);
    got = 1'b0;
    d   = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack_o : m1_ack_o) begin
        got = 1'b1;
        d   = (m == 0) ? m0_dat_o : m1_dat_o;
        break;
      end
      step();
    end
  endtask

  typedef struct {
    logic        m0c, m0s, m1c, m1s, ack;
    logic [31:0] dat;
    logic [5:0]  ctl;   // {s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err}
    logic [31:0] adr, d0, d1;
  } vec_t;

  function automatic vec_t mk(input logic m0c, m0s, m1c, m1s, ack, input logic [31:0] dat,
                              input logic [5:0] ctl, input logic [31:0] adr, d0, d1);
    vec_t v;
    v.m0c = m0c; v.m0s = m0s; v.m1c = m1c; v.m1s = m1s; v.ack = ack; v.dat = dat;
    v.ctl = ctl; v.adr = adr; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  vec_t tv [17];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit          got;
    logic [31:0] rd;
    int          s0, s1, errcnt, erridx;

    tv[0]  = mk(0,0,0,0,0, 32'h0,  6'b000000, 32'h0,    32'h0,  32'h0);
    tv[1]  = mk(1,1,1,1,0, 32'h0,  6'b000000, 32'h0,    32'h0,  32'h0);
    tv[2]  = mk(1,1,1,1,1, 32'h11, 6'b111000, 32'h1000, 32'h11, 32'h0);
    tv[3]  = mk(0,0,1,1,0, 32'h0,  6'b000000, 32'h1000, 32'h0,  32'h0);
    tv[4]  = mk(1,1,1,1,0, 32'h0,  6'b000000, 32'h0,    32'h0,  32'h0);
    tv[5]  = mk(1,1,1,1,1, 32'h22, 6'b110010, 32'h2000, 32'h0,  32'h22);
    tv[6]  = mk(1,1,0,0,0, 32'h0,  6'b000000, 32'h2000, 32'h0,  32'h0);
    tv[7]  = mk(1,1,1,1,0, 32'h0,  6'b000000, 32'h0,    32'h0,  32'h0);
    tv[8]  = mk(1,1,1,1,0, 32'h33, 6'b110000, 32'h1000, 32'h33, 32'h0);
    tv[9]  = mk(1,0,1,1,0, 32'h0,  6'b100000, 32'h1000, 32'h0,  32'h0);
    tv[10] = mk(1,1,1,1,1, 32'h44, 6'b111000, 32'h1000, 32'h44, 32'h0);
    tv[11] = mk(0,0,0,0,0, 32'h0,  6'b000000, 32'h1000, 32'h0,  32'h0);
    tv[12] = mk(0,0,0,0,0, 32'h0,  6'b000000, 32'h0,    32'h0,  32'h0);
    tv[13] = mk(0,0,1,1,0, 32'h0,  6'b000000, 32'h0,    32'h0,  32'h0);
    tv[14] = mk(0,0,1,1,0, 32'h55, 6'b110000, 32'h2000, 32'h0,  32'h55);
    tv[15] = mk(0,0,0,0,0, 32'h0,  6'b000000, 32'h2000, 32'h0,  32'h0);
    tv[16] = mk(0,0,0,0,0, 32'h0,  6'b000000, 32'h0,    32'h0,  32'h0);

    m0_dat_i = 32'hA0A0A0A0; m0_adr_i = 32'h1000; m0_sel_i = 4'hF; m0_we_i = 1'b0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_cti_i = CTI_CLASSIC;
    m1_dat_i = 32'hB1B1B1B1; m1_adr_i = 32'h2000; m1_sel_i = 4'h3; m1_we_i = 1'b0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_cti_i = CTI_CLASSIC;
    model_en = 1'b0; tb_ack = 1'b0; tb_dat = '0;

    rst_n = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {26'h0, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 32'h0);
    chk("reset_adr", s_adr_o, 32'h0);
    chk("reset_dat", s_dat_o | m0_dat_o | m1_dat_o, 32'h0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    rst_n = 1'b1;

    // per-cycle vectors, PRIO_M0=0: tie alternates m0, m1, m0 with IDLE gaps
    for (int i = 0; i < 17; i++) begin
      step();
      m0_cyc_i = tv[i].m0c; m0_stb_i = tv[i].m0s;
      m1_cyc_i = tv[i].m1c; m1_stb_i = tv[i].m1s;
      tb_ack = tv[i].ack; tb_dat = tv[i].dat;
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i),
          {26'h0, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, {26'h0, tv[i].ctl});
      chk($sformatf("vec%0d_adr", i), s_adr_o, tv[i].adr);
      chk($sformatf("vec%0d_dat", i), m0_dat_o ^ {m1_dat_o[15:0], m1_dat_o[31:16]},
          tv[i].d0 ^ {tv[i].d1[15:0], tv[i].d1[31:16]});
    end
    tb_ack = 1'b0; tb_dat = '0;

    // single write then read-back through the RAM model
    model_en = 1'b1;
    s0 = a0; s1 = a1;
    step();
    m0_we_i = 1'b1; m0_adr_i = 32'h1000; m0_dat_i = 32'hDEADBEEF; m0_sel_i = 4'hF;
    m0_cti_i = CTI_CLASSIC; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    @(negedge clk);
    chk("wr_lat_idle", {31'h0, s_cyc_o}, 32'h0);
    step(); @(negedge clk);
    chk("wr_lat_gnt", {31'h0, s_cyc_o}, 32'h1);
    chk("wr_sel", {28'h0, s_sel_o}, 32'hF);
    wait_ack(0, got, rd);
    chk("wr_ack", {31'h0, got}, 32'h1);
    step(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    step(); step();
    chk("wr_ack_once", a0 - s0, 1);
    chk("wr_m1_quiet", a1 - s1, 0);
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    wait_ack(0, got, rd);
    chk("rd_ack", {31'h0, got}, 32'h1);
    chk("rd_data", rd, 32'hDEADBEEF);
    step(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step(); step();

    // fixed priority instance: m0 wins every tie, m1 only when m0 idle in IDLE
    step(); m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    step(); @(negedge clk);
    chk("prio_tie1", p_s_adr_o, 32'h1000);
    step(); m0_cyc_i = 1'b0; @(negedge clk);
    chk("prio_release", {31'h0, p_s_cyc_o}, 32'h0);
    step(); m0_cyc_i = 1'b1;
    step(); @(negedge clk);
    chk("prio_tie2", p_s_adr_o, 32'h1000);
    step(); m0_cyc_i = 1'b0;
    step();
    step(); @(negedge clk);
    chk("prio_m1", p_s_adr_o, 32'h2000);
    step(); m1_cyc_i = 1'b0;
    step(); step();

    // 4-beat m0 burst while m1 waits
    step(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = CTI_INCR;
    step(); m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    s1 = a1;
    for (int b = 0; b < 4; b++) begin
      m0_adr_i = 32'h1000 + 32'(4 * b);
      m0_cti_i = (b == 3) ? CTI_EOB : CTI_INCR;
      wait_ack(0, got, rd);
      chk($sformatf("burst_ack%0d", b), {31'h0, got}, 32'h1);
      chk($sformatf("burst_own%0d", b), s_adr_o, 32'h1000 + 32'(4 * b));
      step();
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_cti_i = CTI_CLASSIC; m0_adr_i = 32'h1000;
    @(negedge clk);
    chk("burst_drop", {31'h0, s_cyc_o}, 32'h0);
    chk("burst_m1_wait", a1 - s1, 0);
    step(); @(negedge clk);
    chk("burst_gap", {31'h0, s_cyc_o}, 32'h0);
    step(); @(negedge clk);
    chk("burst_m1_gnt", {s_cyc_o, s_adr_o[30:0]}, 32'h80002000);
    wait_ack(1, got, rd);
    chk("burst_m1_ack", {31'h0, got}, 32'h1);
    step(); m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step(); step();

    // watchdog: slave never acks; err on 16th strobed cycle, ack wins on 32nd
    model_en = 1'b0; tb_ack = 1'b0;
    errcnt = 0; erridx = 0;
    step(); m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 33; i++) begin
      step();
      tb_ack = (i == 32);
      @(negedge clk);
      if (m1_err_o) begin errcnt++; erridx = i; end
      if (i == 16) chk("wd_stb_drop", {31'h0, s_stb_o}, 32'h0);
      if (i == 15 || i == 17) chk($sformatf("wd_stb%0d", i), {31'h0, s_stb_o}, 32'h1);
      if (i == 32) chk("wd_ack_wins", {30'h0, m1_ack_o, m1_err_o}, 32'h2);
    end
    chk("wd_err_count", errcnt, 1);
    chk("wd_err_cycle", erridx, 16);
    tb_ack = 1'b0;
    step(); m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step(); step();

    // async reset mid-burst, then tie goes to m0 again
    model_en = 1'b1;
    step(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = CTI_INCR;
    step(); @(negedge clk);
    chk("rst_pre", {31'h0, s_cyc_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", {26'h0, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 32'h0);
    chk("rst_async_adr", s_adr_o | m0_dat_o, 32'h0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_cti_i = CTI_CLASSIC;
    step(); rst_n = 1'b1;
    step(); m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    @(negedge clk);
    chk("rst_idle", {31'h0, s_cyc_o}, 32'h0);
    step(); @(negedge clk);
    chk("rst_tie_m0", s_adr_o, 32'h1000);
    step(); m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter for the shared data RAM slave.
- m0 is the MIPS core data port; m1 is the UART loader/DMA master.
- Grants the slave to one master per bus cycle (held for the whole cyc_i assertion, bursts included) and routes the slave response back to that master only.
- Adds a bus watchdog that returns err to a master whose access is never acknowledged.

Parameters:
- TIMEOUT, 16, cycles a granted strobe may wait for ack before err is raised; range 2..255.
- PRIO_M0, 1'b0, 1 = fixed priority to m0; 0 = round-robin.

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- m0_dat_i, m0_adr_i  in  32 each  master 0 write data / address
- m0_sel_i  in  4  master 0 byte selects
- m0_we_i, m0_cyc_i, m0_stb_i  in  1 each  master 0 control
- m0_cti_i  in  3  master 0 cycle type
- m0_dat_o  out  32  read data to master 0
- m0_ack_o, m0_err_o  out  1 each  responses to master 0
- m1_* : same set as m0_*, for master 1
- s_dat_o, s_adr_o  out  32 each  to slave
- s_sel_o  out  4  to slave
- s_we_o, s_cyc_o, s_stb_o  out  1 each  to slave
- s_cti_o  out  3  to slave
- s_dat_i  in  32  slave read data
- s_ack_i  in  1  slave acknowledge

Behaviour:
- FSM states: IDLE, GNT0, GNT1. Registered state, a last-grant pointer lg (1 bit) and an 8-bit watchdog counter wd.
- Reset (rst_ni low, async): state=IDLE, lg=1 (m0 wins first tie), wd=0.
- Reset output values: all s_* = 0, all m*_ack_o = 0, all m*_err_o = 0, m*_dat_o = 0.
- IDLE:
  - req0 = m0_cyc_i, req1 = m1_cyc_i.
  - Only one request -> grant that master.
  - Both requesting: PRIO_M0=1 -> GNT0; otherwise grant the master that is not lg.
  - Grant registers next edge; slave sees cyc/stb one cycle after a master raises cyc. Arbitration latency is exactly 1 cycle.
- GNTx:
  - s_cyc_o = mx_cyc_i, s_stb_o = mx_stb_i; adr/dat/sel/we/cti are muxed from mx combinationally.
  - mx_ack_o = s_ack_i; mx_dat_o = s_dat_i. The non-granted master sees ack=0, err=0, dat=0.
  - On entry, lg <= x.
- Release: when mx_cyc_i is low in GNTx, state <= IDLE and s_cyc_o/s_stb_o drop the same cycle (combinational). This forces at least one IDLE cycle between owners, so the slave ack register drains.
- Burst hold: grant is never revoked while mx_cyc_i is high, whatever the other master requests. Covers cti=010 incrementing bursts and slave ack held across beats.
- Watchdog:
  - In GNTx, wd increments each cycle with mx_stb_i=1 and s_ack_i=0.
  - wd clears on s_ack_i, on stb low, or on leaving GNTx.
  - When wd == TIMEOUT-1 and no ack: mx_err_o=1 for exactly one cycle, s_stb_o forced to 0 that cycle, wd <= 0.
  - err and ack are never asserted together.
- Simultaneous events:
  - ack and the timeout threshold in the same cycle: ack wins, no err.
  - Release of mx and a request from my in the same cycle: still goes via IDLE.
- Reset mid-transfer: all outputs drop asynchronously; the slave's own ack register is reset by the system reset.
- No registered datapath: the mux is purely combinational. Only the FSM, lg and wd are state.

Decomposition:
- Shared package wb_pkg (Verilog include wb_defs.vh):
  - CTI codes: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - State encodings: ARB_IDLE=2'd0, ARB_GNT0=2'd1, ARB_GNT1=2'd2.
- One natural sub-module: wb_watchdog (counter, TIMEOUT compare, err pulse). The arbiter FSM and mux stay in wb_ram_arbiter.

Test Plan:
- Single m0 write: adr=0x1000, dat=0xDEADBEEF, sel=4'hF, cti=000, with a 1-cycle-ack slave -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o pulses once; m1_ack_o stays 0; a following read returns 0xDEADBEEF.
- Both masters raise cyc in the same cycle, PRIO_M0=0, three repetitions -> grants alternate m0, m1, m0 (lg starts at 1); each handover has one IDLE cycle.
- PRIO_M0=1 with both requesting continuously -> m0 always wins; m1 granted only when m0_cyc_i is low in IDLE.
- m0 4-beat burst (cti 010,010,010,111) while m1 requests -> m0 keeps the grant for all 4 acks; m1 is granted 2 cycles after m0_cyc_i falls.
- Slave with ack tied 0, TIMEOUT=16, m1 strobes -> m1_err_o high exactly on the 16th strobed cycle for one cycle; s_stb_o is 0 in that cycle; counter restarts after.
- rst_ni pulled low mid-burst -> all outputs 0 immediately (async); after release the state is IDLE and the next both-request tie goes to m0.
